// File: rtl/aidan_mcnay_prime_seq.sv
// rtl/aidan_mcnay_prime_seq.sv - trial-division primality sequencer driving an iterative remainder unit
module aidan_mcnay_prime_seq #(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] num,
    input  logic             istream_val,
    output logic             istream_rdy,
    output logic             is_prime,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] div_opa,
    output logic [nbits-1:0] div_opb,
    output logic             div_istream_val,
    input  logic             div_istream_rdy,
    input  logic [nbits-1:0] div_result,
    input  logic             div_ostream_val,
    output logic             div_ostream_rdy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [nbits-1:0] ONE  = nbits'(1);
    localparam logic [nbits-1:0] TWO  = nbits'(2);
    localparam logic [nbits-1:0] FOUR = nbits'(4);

    state_t           state_q, state_d;
    logic [nbits-1:0] n_q, n_d;
    logic [nbits-1:0] d_q, d_d;
    logic             prime_q, prime_d;

    // Square is formed at double width so the d*d > N test never overflows.
    logic [2*nbits-1:0] d_sq;
    logic [2*nbits-1:0] n_wide;

    assign d_sq   = {{nbits{1'b0}}, d_q} * {{nbits{1'b0}}, d_q};
    assign n_wide = {{nbits{1'b0}}, n_q};

    assign div_opa  = n_q;
    assign div_opb  = d_q;
    assign is_prime = prime_q;

    always_comb begin
        state_d         = state_q;
        n_d             = n_q;
        d_d             = d_q;
        prime_d         = prime_q;
        istream_rdy     = 1'b0;
        ostream_val     = 1'b0;
        div_istream_val = 1'b0;
        div_ostream_rdy = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    n_d = num;
                    d_d = TWO;
                    if (num < TWO) begin
                        prime_d = 1'b0;
                        state_d = ST_DONE;
                    end else if (num < FOUR) begin
                        prime_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (d_sq > n_wide) begin
                    prime_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                div_istream_val = 1'b1;
                if (div_istream_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                div_ostream_rdy = 1'b1;
                if (div_ostream_val) begin
                    if (div_result == '0) begin
                        prime_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        d_d     = d_q + ONE;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            d_q     <= TWO;
            prime_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            prime_q <= prime_d;
        end
    end

endmodule

// File: tb/tb_aidan_mcnay_prime_seq.sv
// tb/tb_aidan_mcnay_prime_seq.sv - scoreboard bench for the primality sequencer with a behavioural divider
module tb_aidan_mcnay_prime_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] num = '0;
    logic        istream_val = 1'b0;
    logic        istream_rdy;
    logic        is_prime;
    logic        ostream_val;
    logic        ostream_rdy = 1'b1;
    logic [15:0] div_opa;
    logic [15:0] div_opb;
    logic        div_istream_val;
    logic        div_istream_rdy = 1'b0;
    logic [15:0] div_result = '0;
    logic        div_ostream_val = 1'b0;
    logic        div_ostream_rdy;

    aidan_mcnay_prime_seq #(.nbits(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .num             (num),
        .istream_val     (istream_val),
        .istream_rdy     (istream_rdy),
        .is_prime        (is_prime),
        .ostream_val     (ostream_val),
        .ostream_rdy     (ostream_rdy),
        .div_opa         (div_opa),
        .div_opb         (div_opb),
        .div_istream_val (div_istream_val),
        .div_istream_rdy (div_istream_rdy),
        .div_result      (div_result),
        .div_ostream_val (div_ostream_val),
        .div_ostream_rdy (div_ostream_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit prime;
        int reqs;
        int last_d;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    int          cur_n = 0;
    logic [15:0] exp_d = 16'd2;
    int          req_count = 0;
    int          last_opb = 0;

    int          div_lat = 0;
    bit          div_stall = 0;
    bit          div_flush = 0;
    bit          busy = 0;
    int          cnt = 0;
    logic [15:0] res = '0;
    bit          req_pend = 0;
    bit          resp_pend = 0;
    logic [15:0] opa_pend = '0;
    logic [15:0] opb_pend = '0;

    function automatic void ref_model(input int n, output bit p, output int r, output int ld);
        r  = 0;
        ld = 0;
        p  = (n >= 2);
        for (int d = 2; d * d <= n; d++) begin
            r++;
            ld = d;
            if (n % d == 0) begin
                p = 0;
                break;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) div_flush = 1;
    end

    // Behavioural remainder unit; handshakes observed at one negedge complete at the following posedge.
    always @(negedge clk) begin
        if (div_flush) begin
            busy            = 0;
            req_pend        = 0;
            resp_pend       = 0;
            div_ostream_val = 1'b0;
            div_flush       = 0;
        end
        if (resp_pend) begin
            div_ostream_val = 1'b0;
            busy            = 0;
        end
        if (req_pend) begin
            req_count++;
            last_opb = int'(opb_pend);
            checks++;
            if (opa_pend !== cur_n[15:0] || opb_pend !== exp_d) begin
                errors++;
                $display("FAIL div_request: got (%0d,%0d) expected (%0d,%0d)", opa_pend, opb_pend, cur_n, exp_d);
            end
            exp_d = exp_d + 16'd1;
            res   = (opb_pend == 16'd0) ? 16'd0 : (opa_pend % opb_pend);
            busy  = 1;
            cnt   = div_lat;
        end
        div_istream_rdy = !busy && !div_stall;
        if (busy && !div_ostream_val) begin
            if (cnt == 0) begin
                div_ostream_val = 1'b1;
                div_result      = res;
            end else begin
                cnt--;
            end
        end
        req_pend  = div_istream_val && div_istream_rdy;
        opa_pend  = div_opa;
        opb_pend  = div_opb;
        resp_pend = div_ostream_val && div_ostream_rdy;
    end

    always @(negedge clk) begin
        if (!reset && ostream_val && ostream_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: is_prime=%0d with empty scoreboard", is_prime);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (is_prime !== e.prime) begin
                    errors++;
                    $display("FAIL is_prime n=%0d: got %0d expected %0d", cur_n, is_prime, e.prime);
                end
                checks++;
                if (req_count != e.reqs) begin
                    errors++;
                    $display("FAIL req_count n=%0d: got %0d expected %0d", cur_n, req_count, e.reqs);
                end
                if (e.reqs > 0) begin
                    checks++;
                    if (last_opb != e.last_d) begin
                        errors++;
                        $display("FAIL last_divisor n=%0d: got %0d expected %0d", cur_n, last_opb, e.last_d);
                    end
                end
            end
        end
    end

    task automatic send(input int n);
        bit p;
        int r;
        int ld;
        int b;
        ref_model(n, p, r, ld);
        exp_q.push_back('{prime: p, reqs: r, last_d: ld});
        num         = 16'(n);
        istream_val = 1'b1;
        b           = 0;
        while (!istream_rdy && b < 5000) begin
            @(negedge clk);
            b++;
        end
        if (!istream_rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout n=%0d: istream_rdy=%0d expected 1", n, istream_rdy);
        end
        cur_n     = n;
        exp_d     = 16'd2;
        req_count = 0;
        last_opb  = 0;
        @(negedge clk);
        istream_val = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 20000) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || div_istream_val !== 1'b0 ||
            div_ostream_rdy !== 1'b0 || is_prime !== 1'b0) begin
            errors++;
            $display("FAIL %s: rdy=%0d oval=%0d dval=%0d drdy=%0d prime=%0d expected 1,0,0,0,0",
                     tag, istream_rdy, ostream_val, div_istream_val, div_ostream_rdy, is_prime);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("reset_state");
    endtask

    task automatic test_small();
        int vals[4] = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++) begin
            send(vals[i]);
            if (vals[i] >= 2) begin
                checks++;
                if (ostream_val !== 1'b1) begin
                    errors++;
                    $display("FAIL done_latency n=%0d: ostream_val=%0d expected 1", vals[i], ostream_val);
                end
            end
            wait_idle();
        end
    endtask

    task automatic test_known();
        int vals[4] = '{9, 97, 65521, 65535};
        for (int i = 0; i < 4; i++) begin
            div_lat = i;
            send(vals[i]);
            wait_idle();
        end
    endtask

    task automatic test_back_to_back();
        int vals[7] = '{4, 5, 25, 49, 121, 169, 251};
        div_lat = 0;
        for (int i = 0; i < 7; i++) send(vals[i]);
        wait_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            div_lat = $urandom_range(0, 3);
            send($urandom_range(0, 65535));
            wait_idle();
        end
    endtask

    task automatic test_out_backpressure();
        int  b;
        bit  p;
        ostream_rdy = 1'b0;
        send(9);
        b = 0;
        while (!ostream_val && b < 200) begin
            @(negedge clk);
            b++;
        end
        p = is_prime;
        checks++;
        if (ostream_val !== 1'b1 || p !== 1'b0) begin
            errors++;
            $display("FAIL bp_reach_done: oval=%0d prime=%0d expected 1,0", ostream_val, p);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (ostream_val !== 1'b1 || is_prime !== p || istream_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: oval=%0d prime=%0d irdy=%0d expected 1,%0d,0",
                         ostream_val, is_prime, istream_rdy, p);
            end
        end
        ostream_rdy = 1'b1;
        wait_idle();
    endtask

    task automatic test_issue_stall();
        int          b;
        logic [15:0] a0;
        logic [15:0] b0;
        div_stall = 1;
        send(97);
        b = 0;
        while (!div_istream_val && b < 50) begin
            @(negedge clk);
            b++;
        end
        a0 = div_opa;
        b0 = div_opb;
        checks++;
        if (div_istream_val !== 1'b1 || a0 !== 16'd97 || b0 !== 16'd2) begin
            errors++;
            $display("FAIL stall_issue: val=%0d opa=%0d opb=%0d expected 1,97,2", div_istream_val, a0, b0);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (div_istream_val !== 1'b1 || div_opa !== a0 || div_opb !== b0) begin
                errors++;
                $display("FAIL stall_hold: val=%0d opa=%0d opb=%0d expected 1,%0d,%0d",
                         div_istream_val, div_opa, div_opb, a0, b0);
            end
        end
        div_stall = 0;
        wait_idle();
    endtask

    task automatic test_reset_in_wait();
        int b;
        div_lat = 6;
        send(97);
        b = 0;
        while (!div_ostream_rdy && b < 50) begin
            @(negedge clk);
            b++;
        end
        checks++;
        if (div_ostream_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reach_wait: div_ostream_rdy=%0d expected 1", div_ostream_rdy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check_reset_outputs("reset_in_wait");
        div_lat = 1;
        send(9);
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_small();
        test_known();
        test_back_to_back();
        test_out_backpressure();
        test_issue_stall();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
